uart_rx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_cfg_if.sv | 24 ++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx_cfg.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver and its future transmitter twin:
// frame state encoding, parity-mode constants and the mid-bit sample index.
package uart_pkg;

  typedef enum logic [2:0] {
    S_Idle   = 3'd0,
    S_Start  = 3'd1,
    S_Data   = 3'd2,
    S_Parity = 3'd3,
    S_Stop   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int sample_point(input int osr);
    return osr / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Handshake bundle between the UART receiver (master) and its byte consumer (slave).
interface uart_rx_cfg_if #(parameter int DWL = 8);

  logic           EN;
  logic           serialData;
  logic           rAck;
  logic           rByte;
  logic [DWL-1:0] rData;
  logic           parityErr;
  logic           frameErr;
  logic           breakDet;
  logic           overrun;

  modport master (
    input  EN, serialData, rAck,
    output rByte, rData, parityErr, frameErr, breakDet, overrun
  );

  modport slave (
    output EN, serialData, rAck,
    input  rByte, rData, parityErr, frameErr, breakDet, overrun
  );

endinterface

// File: rtl/uart_sync.sv
// N-stage synchroniser for the asynchronous serial pin.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: reset to 1 so a freshly reset receiver sees an idle line, not a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DWL data bits, optional parity, 1-2 stop bits,
// OSR-times oversampled on EN ticks, with a held valid/acknowledge output.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DWL         = 8,
  parameter int OSR         = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_cfg_if.master bus
);

  localparam int SW = $clog2(OSR);
  localparam int BW = $clog2(DWL + 1);
  localparam logic [SW-1:0] SP        = SW'(sample_point(OSR));
  localparam logic [SW-1:0] LAST      = SW'(OSR - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DWL - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic           rx_line;
  uart_state_e    state, state_n;
  logic [SW-1:0]  sample, sample_n;
  logic [BW-1:0]  bitc, bitc_n;
  logic [DWL-1:0] shreg, shreg_n;
  logic           par_bit, par_bit_n;
  logic           stop_low, stop_low_n;
  logic           first_low, first_low_n;
  logic           done;
  logic           word_perr, word_ferr, word_brk;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (bus.serialData),
    .q   (rx_line)
  );

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    sample_n    = sample;
    bitc_n      = bitc;
    shreg_n     = shreg;
    par_bit_n   = par_bit;
    stop_low_n  = stop_low;
    first_low_n = first_low;
    done        = 1'b0;
    if (bus.EN) begin
      case (state)
        S_Idle: begin
          if (!rx_line) begin
            state_n  = S_Start;
            sample_n = '0;
          end
        end
        S_Start: begin
          if (sample == SP && rx_line) begin
            state_n  = S_Idle;
            sample_n = '0;
          end else if (sample == LAST) begin
            state_n     = S_Data;
            sample_n    = '0;
            bitc_n      = '0;
            shreg_n     = '0;
            par_bit_n   = 1'b0;
            stop_low_n  = 1'b0;
            first_low_n = 1'b0;
          end else begin
            sample_n = sample + 1'b1;
          end
        end
        S_Data: begin
          // Shifting in from the top leaves the first-received bit at the LSB.
          if (sample == SP) shreg_n = {rx_line, shreg[DWL-1:1]};
          if (sample == LAST) begin
            sample_n = '0;
            if (bitc == LAST_BIT) begin
              bitc_n  = '0;
              state_n = (PARITY_EN != 0) ? S_Parity : S_Stop;
            end else begin
              bitc_n = bitc + 1'b1;
            end
          end else begin
            sample_n = sample + 1'b1;
          end
        end
        S_Parity: begin
          if (sample == SP) par_bit_n = rx_line;
          if (sample == LAST) begin
            state_n  = S_Stop;
            sample_n = '0;
            bitc_n   = '0;
          end else begin
            sample_n = sample + 1'b1;
          end
        end
        S_Stop: begin
          if (sample == SP) begin
            stop_low_n = stop_low | ~rx_line;
            if (bitc == '0) first_low_n = ~rx_line;
          end
          // Finishing at mid-bit leaves half a bit to catch a back-to-back start edge.
          if (sample == SP && bitc == LAST_STOP) begin
            done     = 1'b1;
            state_n  = S_Idle;
            sample_n = '0;
            bitc_n   = '0;
          end else if (sample == LAST) begin
            sample_n = '0;
            bitc_n   = bitc + 1'b1;
          end else begin
            sample_n = sample + 1'b1;
          end
        end
        default: begin
          state_n  = S_Idle;
          sample_n = '0;
          bitc_n   = '0;
        end
      endcase
    end
  end

  // Flags for the word completing this cycle; the live sample is the last stop bit.
  always_comb begin
    word_ferr = stop_low | ~rx_line;
    word_brk  = (shreg == '0) && !par_bit && ((bitc == '0) ? ~rx_line : first_low);
    word_perr = (PARITY_EN != 0) && ((^shreg ^ par_bit ^ PAR_MODE) != 1'b0);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_Idle;
      sample    <= '0;
      bitc      <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop_low  <= 1'b0;
      first_low <= 1'b0;
    end else begin
      state     <= state_n;
      sample    <= sample_n;
      bitc      <= bitc_n;
      shreg     <= shreg_n;
      par_bit   <= par_bit_n;
      stop_low  <= stop_low_n;
      first_low <= first_low_n;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.rByte     <= 1'b0;
      bus.rData     <= '0;
      bus.parityErr <= 1'b0;
      bus.frameErr  <= 1'b0;
      bus.breakDet  <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (done && (!bus.rByte || bus.rAck)) begin
        bus.rByte     <= 1'b1;
        bus.rData     <= shreg;
        bus.parityErr <= word_perr;
        bus.frameErr  <= word_ferr;
        bus.breakDet  <= word_brk;
      end else if (bus.rAck && bus.rByte) begin
        bus.rByte     <= 1'b0;
        bus.parityErr <= 1'b0;
        bus.frameErr  <= 1'b0;
        bus.breakDet  <= 1'b0;
      end
      if (done && bus.rByte && !bus.rAck) bus.overrun <= 1'b1;
      else if (bus.rAck)                  bus.overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three configurations, directed frames plus
// randomized frames compared against a frame-level reference model.
module tb_uart_rx_cfg;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] ser = 3'b111;
  logic [2:0] ack = 3'b000;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  // EN: one CLK wide, every 4th CLK, changed on the falling edge.
  initial begin : en_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge CLK);
      ph = (ph + 1) % 4;
      en = (ph == 0);
    end
  end

  // Instance 0: 8N1. Instance 1: 8E1. Instance 2: 9 bits, odd parity, 2 stop bits.
  int cfg_dwl   [3] = '{8, 8, 9};
  bit cfg_pen   [3] = '{1'b0, 1'b1, 1'b1};
  bit cfg_podd  [3] = '{1'b0, 1'b0, 1'b1};
  int cfg_nstop [3] = '{1, 1, 2};

  uart_rx_cfg_if #(.DWL(8)) bus_a ();
  uart_rx_cfg_if #(.DWL(8)) bus_b ();
  uart_rx_cfg_if #(.DWL(9)) bus_c ();

  assign bus_a.EN = en;  assign bus_a.serialData = ser[0];  assign bus_a.rAck = ack[0];
  assign bus_b.EN = en;  assign bus_b.serialData = ser[1];  assign bus_b.rAck = ack[1];
  assign bus_c.EN = en;  assign bus_c.serialData = ser[2];  assign bus_c.rAck = ack[2];

  uart_rx_cfg #(.DWL(8), .OSR(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2))
    dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
  uart_rx_cfg #(.DWL(8), .OSR(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2))
    dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));
  uart_rx_cfg #(.DWL(9), .OSR(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .SYNC_STAGES(3))
    dut_c (.CLK(CLK), .RST(RST), .bus(bus_c));

  logic [2:0] o_valid, o_perr, o_ferr, o_brk, o_ovr;
  logic [8:0] o_data_a, o_data_b, o_data_c;
  assign o_valid  = {bus_c.rByte,     bus_b.rByte,     bus_a.rByte};
  assign o_perr   = {bus_c.parityErr, bus_b.parityErr, bus_a.parityErr};
  assign o_ferr   = {bus_c.frameErr,  bus_b.frameErr,  bus_a.frameErr};
  assign o_brk    = {bus_c.breakDet,  bus_b.breakDet,  bus_a.breakDet};
  assign o_ovr    = {bus_c.overrun,   bus_b.overrun,   bus_a.overrun};
  assign o_data_a = {1'b0, bus_a.rData};
  assign o_data_b = {1'b0, bus_b.rData};
  assign o_data_c = bus_c.rData;

  // Reference model: what the consumer should currently see on each receiver.
  logic       m_valid [3];
  logic [8:0] m_data  [3];
  logic       m_perr  [3];
  logic       m_ferr  [3];
  logic       m_brk   [3];
  logic       m_ovr   [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [8:0] get_data(input int idx);
    case (idx)
      0:       return o_data_a;
      1:       return o_data_b;
      default: return o_data_c;
    endcase
  endfunction

  task automatic check_out(input int idx, input string tag);
    check({tag, ".rByte"},     32'(o_valid[idx[1:0]]), 32'(m_valid[idx]));
    check({tag, ".rData"},     32'(get_data(idx)),     32'(m_data[idx]));
    check({tag, ".parityErr"}, 32'(o_perr[idx[1:0]]),  32'(m_perr[idx]));
    check({tag, ".frameErr"},  32'(o_ferr[idx[1:0]]),  32'(m_ferr[idx]));
    check({tag, ".breakDet"},  32'(o_brk[idx[1:0]]),   32'(m_brk[idx]));
    check({tag, ".overrun"},   32'(o_ovr[idx[1:0]]),   32'(m_ovr[idx]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0; m_data[i] = '0; m_perr[i] = 1'b0;
      m_ferr[i]  = 1'b0; m_brk[i]  = 1'b0; m_ovr[i]  = 1'b0;
    end
  endtask

  task automatic model_frame(input int idx, input logic [8:0] d, input bit perr,
                             input bit ferr, input bit brk, input bit acked);
    if (m_valid[idx] && !acked) begin
      m_ovr[idx] = 1'b1;
    end else begin
      m_valid[idx] = 1'b1; m_data[idx] = d;
      m_perr[idx]  = perr; m_ferr[idx] = ferr; m_brk[idx] = brk;
      if (acked) m_ovr[idx] = 1'b0;
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      while (!en) @(posedge CLK);
    end
  endtask

  // One acknowledge cycle; called #1 after a rising edge.
  task automatic do_ack(input int idx);
    ack[idx] = 1'b1;
    @(posedge CLK);
    #1 ack[idx] = 1'b0;
    if (m_valid[idx]) begin
      m_valid[idx] = 1'b0; m_perr[idx] = 1'b0; m_ferr[idx] = 1'b0; m_brk[idx] = 1'b0;
    end
    m_ovr[idx] = 1'b0;
  endtask

  // Drives one frame, 16 EN ticks per bit. limit truncates the frame; ack_end pulses
  // rAck on the EN tick holding the last stop bit's mid-point (2 sync stages + 1 tick).
  task automatic send(input int idx, input logic [8:0] data, input bit flip,
                      input bit s1_low, input bit s2_low, input int limit,
                      input bit ack_end, input int gap);
    logic       bits [16];
    int         n;
    logic [8:0] d;
    logic       pbit;
    bit         perr, ferr, brk;
    n    = 0;
    d    = data & 9'((1 << cfg_dwl[idx]) - 1);
    pbit = (^d) ^ cfg_podd[idx] ^ flip;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < cfg_dwl[idx]; i++) begin bits[n] = d[i]; n++; end
    if (cfg_pen[idx]) begin bits[n] = pbit; n++; end
    bits[n] = ~s1_low; n++;
    if (cfg_nstop[idx] == 2) begin bits[n] = ~s2_low; n++; end
    wait_ticks(1);
    for (int b = 0; b < n && b < limit; b++) begin
      #1 ser[idx] = bits[b];
      if (ack_end && b == n - 1) begin
        wait_ticks(8);
        repeat (3) @(posedge CLK);
        #1 ack[idx] = 1'b1;
        @(posedge CLK);
        #1 ack[idx] = 1'b0;
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    if (limit >= n) begin
      perr = cfg_pen[idx] && flip;
      ferr = s1_low || (cfg_nstop[idx] == 2 && s2_low);
      brk  = (d == '0) && (!cfg_pen[idx] || !pbit) && s1_low;
      model_frame(idx, d, perr, ferr, brk, ack_end);
    end
    if (gap > 0) begin
      #1 ser[idx] = 1'b1;
      wait_ticks(gap);
      #1;
    end
  endtask

  initial begin : main
    logic [8:0] rd;
    bit         rflip, rs1, rs2;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) check_out(i, $sformatf("reset%0d", i));
    @(negedge CLK) RST = 1'b0;
    wait_ticks(4);
    #1;

    // 8N1 basic word and acknowledge.
    send(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 99, 1'b0, 20);
    check_out(0, "a5");
    do_ack(0);
    check_out(0, "a5_ack");

    // Even parity: wrong parity bit, then correct one.
    send(1, 9'h007, 1'b1, 1'b0, 1'b0, 99, 1'b0, 20);
    check_out(1, "par_bad");
    do_ack(1);
    send(1, 9'h007, 1'b0, 1'b0, 1'b0, 99, 1'b0, 20);
    check_out(1, "par_ok");
    do_ack(1);

    // Short low glitch is rejected, a following frame is still received.
    wait_ticks(1);
    #1 ser[0] = 1'b0;
    wait_ticks(3);
    #1 ser[0] = 1'b1;
    wait_ticks(24);
    #1;
    check_out(0, "glitch");
    send(0, 9'h03C, 1'b0, 1'b0, 1'b0, 99, 1'b0, 20);
    check_out(0, "after_glitch");
    do_ack(0);

    // Low stop bit: break on all-zero data, framing error only otherwise.
    send(0, 9'h000, 1'b0, 1'b1, 1'b0, 99, 1'b0, 20);
    check_out(0, "break");
    do_ack(0);
    send(0, 9'h055, 1'b0, 1'b1, 1'b0, 99, 1'b0, 20);
    check_out(0, "frame_err");
    do_ack(0);
    check_out(0, "frame_err_ack");

    // Back-to-back frames: overrun without acknowledge, then ack on completion cycle.
    send(0, 9'h011, 1'b0, 1'b0, 1'b0, 99, 1'b0, 0);
    send(0, 9'h022, 1'b0, 1'b0, 1'b0, 99, 1'b0, 20);
    check_out(0, "overrun");
    do_ack(0);
    check_out(0, "overrun_ack");
    send(0, 9'h011, 1'b0, 1'b0, 1'b0, 99, 1'b0, 0);
    send(0, 9'h022, 1'b0, 1'b0, 1'b0, 99, 1'b1, 20);
    check_out(0, "ack_wins");
    do_ack(0);

    // 9-bit, two stop bits; reset mid-frame, then a clean frame.
    send(2, 9'h1FF, 1'b0, 1'b0, 1'b0, 99, 1'b0, 20);
    check_out(2, "c_1ff");
    send(2, 9'h0AA, 1'b0, 1'b0, 1'b0, 6, 1'b0, 0);
    @(negedge CLK) RST = 1'b1;
    #1;
    model_reset();
    check_out(2, "c_async_rst");
    ser[2] = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_ticks(4);
    #1;
    send(2, 9'h0AA, 1'b0, 1'b0, 1'b0, 99, 1'b0, 20);
    check_out(2, "c_0aa");
    do_ack(2);

    // Randomized frames on every configuration, acknowledges sometimes skipped.
    for (int idx = 0; idx < 3; idx++) begin
      for (int k = 0; k < 8; k++) begin
        rd    = 9'($urandom);
        rflip = cfg_pen[idx] && ($urandom_range(0, 3) == 0);
        rs1   = ($urandom_range(0, 4) == 0);
        rs2   = ($urandom_range(0, 4) == 0);
        send(idx, rd, rflip, rs1, rs2, 99, 1'b0, 20);
        check_out(idx, $sformatf("rnd%0d_%0d", idx, k));
        if ($urandom_range(0, 3) != 0) begin
          do_ack(idx);
          check_out(idx, $sformatf("rnd%0d_%0d_ack", idx, k));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
